// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop synchronizer, valid/ready holding register, framing and overrun flags
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [15:0] HALF_END = 16'(HALF_BIT - 1);
    localparam logic [15:0] BIT_END = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t      state, state_n;
    logic        rx_m, rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        sample;
    logic        stop_ok;
    logic        load;

    assign busy    = state != IDLE;
    assign stop_ok = state == STOP && sample && rx_s;
    assign load    = stop_ok && (!rx_valid || rx_ready);

    // Bring the asynchronous line into the clock domain; idles high
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rx_m, rx_s} <= 2'b11;
        else        {rx_m, rx_s} <= {rx, rx_m};

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    // Next state; sample marks the single clock on which rx_s is looked at
    always_comb begin
        state_n = state;
        sample  = 1'b0;
        case (state)
            IDLE:      state_n = rx_s ? IDLE : START;
            START: if (cnt == HALF_END) begin
                sample  = 1'b1;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == BIT_END) begin
                sample  = 1'b1;
                state_n = bit_cnt == 3'd7 ? STOP : DATA;
            end
            STOP: if (cnt == BIT_END) begin
                sample  = 1'b1;
                state_n = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
            default:   state_n = IDLE;
        endcase
    end

    // Clock and bit counters plus LSB-first shift register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            cnt     <= (sample || state_n != state || state == IDLE || state == WAIT_IDLE) ? '0 : cnt + 16'd1;
            bit_cnt <= state == START ? 3'd0 : (state == DATA && sample) ? bit_cnt + 3'd1 : bit_cnt;
            shift   <= (state == DATA && sample) ? {rx_s, shift[7:1]} : shift;
        end

    // Holding register handshake and single-cycle error pulses
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_data   <= load ? shift : rx_data;
            rx_valid  <= load ? 1'b1 : (rx_valid && rx_ready) ? 1'b0 : rx_valid;
            frame_err <= state == STOP && sample && !rx_s;
            overrun   <= stop_ok && rx_valid && !rx_ready;
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx driven by a behavioral 8N1 transmitter at 16 clocks per bit
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int nv = 0, nvc = 0, nfe = 0, nov = 0, nbusy = 0;
    int v_cyc = 0, ov_cyc = 0, e0 = 0;
    logic prev_v = 1'b0;
    logic [7:0] q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops on each handshake, counts pulses and busy cycles
    always @(negedge clk) begin
        if (!rst_n) prev_v = 1'b0;
        else begin
            if (rx_valid && !prev_v) begin nv++; v_cyc = cyc; end
            if (rx_valid) nvc++;
            if (rx_valid && rx_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got 0x%02h expected none", rx_data);
                end else begin
                    logic [7:0] e;
                    e = q.pop_front();
                    if (rx_data != e) begin
                        bad++;
                        $display("FAIL rx_data: got 0x%02h expected 0x%02h", rx_data, e);
                    end
                end
            end
            if (frame_err) nfe++;
            if (overrun) begin nov++; ov_cyc = cyc; end
            if (frame_err || overrun) begin
                total++;
                if (frame_err && overrun) begin
                    bad++;
                    $display("FAIL flags_exclusive: got both expected one");
                end
            end
            if (busy) nbusy++;
            prev_v = rx_valid;
        end
    end

    // Behavioral transmitter; call at #1 after a posedge, returns likewise with the line idle
    task automatic send(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        e0 = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = d[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr;
        nv = 0; nvc = 0; nfe = 0; nov = 0; nbusy = 0;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_v;
        int         exp_fe;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{8'h5A, 1'b1, 1, 0};
        tbl[1] = '{8'h01, 1'b1, 1, 0};
        tbl[2] = '{8'h80, 1'b1, 1, 0};
        tbl[3] = '{8'hE7, 1'b0, 0, 1};
        tbl[4] = '{8'hFF, 1'b0, 0, 1};

        #2;
        chk("reset_outputs", int'({rx_data, rx_valid, busy, frame_err, overrun}), 0);
        idle(3);
        rst_n = 1'b1;
        idle(5);

        foreach (tbl[i]) begin
            clr();
            if (tbl[i].exp_v == 1) q.push_back(tbl[i].d);
            send(tbl[i].d, tbl[i].stop);
            idle(20);
            chk($sformatf("tbl%0d_valid", i), nv, tbl[i].exp_v);
            chk($sformatf("tbl%0d_frame_err", i), nfe, tbl[i].exp_fe);
            chk($sformatf("tbl%0d_overrun", i), nov, 0);
            chk($sformatf("tbl%0d_busy", i), int'(busy), 0);
        end

        clr();
        q.push_back(8'hA5);
        send(8'hA5, 1'b1);
        idle(20);
        chk("a5_valid_latency", v_cyc - e0, 154);
        chk("a5_valid_cycles", nvc, 1);
        chk("a5_flags", nfe + nov, 0);
        chk("a5_busy", int'(busy), 0);

        clr();
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        idle(20);
        chk("b2b_valid", nv, 3);
        chk("b2b_frame_err", nfe, 0);
        chk("b2b_pending", q.size(), 0);

        clr();
        rx_ready = 1'b0;
        q.push_back(8'h3C);
        send(8'h3C, 1'b1);
        idle(5);
        send(8'hC3, 1'b1);
        idle(20);
        chk("ovr_count", nov, 1);
        chk("ovr_latency", ov_cyc - e0, 154);
        chk("ovr_hold_data", int'(rx_data), 8'h3C);
        chk("ovr_hold_valid", int'(rx_valid), 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(1);
        chk("ovr_consumed", int'(rx_valid), 0);
        chk("ovr_pending", q.size(), 0);
        rx_ready = 1'b1;

        clr();
        send(8'h81, 1'b0);
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(40);
        chk("break_frame_err", nfe, 1);
        chk("break_valid", nv, 0);
        q.push_back(8'h42);
        send(8'h42, 1'b1);
        idle(20);
        chk("break_after_valid", nv, 1);
        chk("break_after_frame_err", nfe, 1);

        clr();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        chk("glitch_valid", nv, 0);
        chk("glitch_flags", nfe + nov, 0);
        chk("glitch_busy_window", int'(nbusy > 0 && nbusy <= 10), 1);

        clr();
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(CPB);
            rx = 1'(8'h99 >> i);
        end
        idle(8);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", int'({rx_data, rx_valid, busy, frame_err, overrun}), 0);
        idle(5);
        chk("midreset_hold", int'({rx_data, rx_valid, busy, frame_err, overrun}), 0);
        rx = 1'b1;
        rst_n = 1'b1;
        idle(10);
        q.push_back(8'h24);
        send(8'h24, 1'b1);
        idle(20);
        chk("midreset_valid", nv, 1);
        chk("midreset_flags", nfe + nov, 0);
        chk("final_pending", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
